// File: rtl/leaf_arb_pkg.sv
// Shared types, default sizing and helpers for the leaf output arbiter.
package leaf_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int PAYLOAD_BITS = 32;
    localparam int MAX_BURST    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request strictly after i_ptr, wrapping.
module rr_pick
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ  = leaf_arb_pkg::NUM_REQ,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [REQ_BITS-1:0] i_ptr,
    output logic                o_found,
    output logic [REQ_BITS-1:0] o_index
);

    logic [REQ_BITS-1:0] w_cand [NUM_REQ];

    // w_cand[n] is the requester examined at search position n (0 = highest priority).
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand[gi] = REQ_BITS'((int'(i_ptr) + gi + 1) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_found = 1'b1;
                o_index = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin burst arbiter sharing one leaf-interface output port among NUM_REQ streams.
module leaf_out_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_REQ      = leaf_arb_pkg::NUM_REQ,
    parameter int REQ_BITS     = 2,
    parameter int PAYLOAD_BITS = leaf_arb_pkg::PAYLOAD_BITS,
    parameter int MAX_BURST    = leaf_arb_pkg::MAX_BURST
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]              req_tvalid,
    output logic [NUM_REQ-1:0]              req_tready,
    output logic [PAYLOAD_BITS-1:0]         dout_user2interface,
    output logic                            vld_user2interface,
    input  logic                            ack_interface2user,
    output logic [REQ_BITS-1:0]             grant_id,
    output logic                            busy
);

    localparam int                     CNT_BITS  = clog2(MAX_BURST) + 1;
    localparam logic [CNT_BITS-1:0]    LAST_BEAT = CNT_BITS'(MAX_BURST - 1);
    localparam logic [REQ_BITS-1:0]    PTR_RST   = REQ_BITS'(NUM_REQ - 1);

    state_t                r_state;
    logic [REQ_BITS-1:0]   r_grant;
    logic [REQ_BITS-1:0]   r_ptr;
    logic [CNT_BITS-1:0]   r_cnt;

    logic                    w_found;
    logic [REQ_BITS-1:0]     w_pick;
    logic [PAYLOAD_BITS-1:0] w_data [NUM_REQ];
    logic                    w_grant_vld;
    logic                    w_xfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_data[gi] = req_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_pick (
        .i_req   (req_tvalid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_pick)
    );

    assign w_grant_vld = req_tvalid[r_grant];
    assign w_xfer      = (r_state == BURST) && w_grant_vld && ack_interface2user && !reset;
    assign busy        = (r_state == BURST);
    assign grant_id    = r_grant;

    // Ready is masked during reset so a beat offered in the reset cycle is not consumed.
    always_comb begin
        req_tready          = '0;
        vld_user2interface  = 1'b0;
        dout_user2interface = '0;
        if (r_state == BURST) begin
            vld_user2interface  = w_grant_vld;
            dout_user2interface = w_data[r_grant];
            if (!reset) begin
                req_tready[r_grant] = ack_interface2user;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (!w_grant_vld || (w_xfer && (r_cnt == LAST_BEAT))) begin
                        r_state <= IDLE;
                        r_ptr   <= r_grant;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
